keycode_ring_buffer: RTL and testbench

KEYCODE_RING_BUFFER -- requirements
Module: keycode_ring_buffer

---
 rtl/keycode_pkg.sv | 15 +
 rtl/rise_detect.sv | 28 ++
 rtl/keycode_ring_buffer.sv | 142 ++++++++++++++
 tb/tb_keycode_ring_buffer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keycode_pkg.sv
// Shared constants for the keycode ring buffer: key width, default depth,
// bus width for zero-extension and the byte stride of one mirrored word.
package keycode_pkg;

  localparam int unsigned KEY_W         = 8;
  localparam int unsigned DEPTH_DEFAULT = 16;
  localparam int unsigned BUS_W         = 32;
  localparam logic [31:0] WORD_BYTES    = 32'd4;

  // Byte offset of a word index inside the mirrored data-memory region.
  function automatic logic [31:0] word_offset(input logic [31:0] idx);
    return idx * WORD_BYTES;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector; stays disarmed for the first clock after reset so a
// level already high at release is absorbed instead of creating a pulse.
module rise_detect
  import keycode_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic pulse
);

  logic prev_q;
  logic armed_q;

  // Registered copy of d and the post-reset arming flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= d;
      armed_q <= 1'b1;
    end
  end

  assign pulse = armed_q & d & ~prev_q;

endmodule

// File: rtl/keycode_ring_buffer.sv
// Keycode FIFO with first-word fall-through head, sticky overflow and a
// one-cycle write mirror toward the data memory for every accepted key.
module keycode_ring_buffer
  import keycode_pkg::*;
#(
  parameter int unsigned DATA_W    = KEY_W,
  parameter int unsigned DEPTH     = DEPTH_DEFAULT,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        key_code,
  input  logic                     data_ready,
  input  logic                     pop,
  input  logic                     clear,
  output logic [31:0]              rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic                     mem_we,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wd
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned PAD_W   = BUS_W - DATA_W;
  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic              push_s;
  logic              do_push_s;
  logic              do_pop_s;
  logic              drop_s;
  logic              empty_s;
  logic              full_s;

  logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
  logic [PTR_W:0]    count_q,    count_d;
  logic              overflow_q, overflow_d;
  logic              mem_we_q,   mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wd_q,   mem_wd_d;
  logic [DATA_W-1:0] store_q [DEPTH];

  rise_detect u_rise_detect (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (data_ready),
    .pulse (push_s)
  );

  assign empty_s = (count_q == '0);
  assign full_s  = (count_q == DEPTH_C);

  // A pop while full frees the slot the simultaneous push needs.
  assign do_pop_s  = pop & ~empty_s;
  assign do_push_s = push_s & (~full_s | do_pop_s);
  assign drop_s    = push_s & full_s & ~pop;

  // Next-state for pointers, occupancy, overflow and the mirror strobe.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_wd_d   = mem_wd_q;
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      mem_we_d   = 1'b0;
    end else begin
      if (do_push_s) begin
        wr_ptr_d   = wr_ptr_q + PTR_ONE;
        mem_we_d   = 1'b1;
        mem_addr_d = BASE_ADDR + word_offset(32'(wr_ptr_q));
        mem_wd_d   = {{PAD_W{1'b0}}, key_code};
      end else begin
        mem_we_d   = 1'b0;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      if (drop_s) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= 32'h0000_0000;
      mem_wd_q   <= 32'h0000_0000;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wd_q   <= mem_wd_d;
    end
  end

  // Key storage; contents are don't-care after clear or reset.
  always_ff @(posedge clk) begin
    if (do_push_s && !clear) begin
      store_q[wr_ptr_q] <= key_code;
    end
  end

  assign rd_data  = empty_s ? 32'h0000_0000 : {{PAD_W{1'b0}}, store_q[rd_ptr_q]};
  assign count    = count_q;
  assign empty    = empty_s;
  assign full     = full_s;
  assign overflow = overflow_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_wd   = mem_wd_q;

endmodule

// File: tb/tb_keycode_ring_buffer.sv
// Scoreboard bench for keycode_ring_buffer: a queue model of the FIFO and a
// queue of expected mirror writes checked by a negedge monitor.
module tb_keycode_ring_buffer;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  key_code = 8'h00;
  logic        data_ready = 1'b0;
  logic        pop = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] rd_data;
  logic [4:0]  count;
  logic        empty, full, overflow, mem_we;
  logic [31:0] mem_addr, mem_wd;

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  model_q[$];
  logic [63:0] wr_q[$];
  logic [63:0] exp_w;
  int          wr_idx = 0;
  bit          exp_ovf = 1'b0;

  keycode_ring_buffer #(.DATA_W(8), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .key_code(key_code), .data_ready(data_ready),
    .pop(pop), .clear(clear), .rd_data(rd_data), .count(count), .empty(empty),
    .full(full), .overflow(overflow), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wd(mem_wd)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      tests++;
      if (wr_q.size() == 0) begin
        fails++;
        $display("FAIL mem_we_unexpected: got addr=%h wd=%h, required no write", mem_addr, mem_wd);
      end else begin
        exp_w = wr_q.pop_front();
        if ({mem_addr, mem_wd} !== exp_w) begin
          fails++;
          $display("FAIL mem_write: got addr=%h wd=%h, required addr=%h wd=%h",
                   mem_addr, mem_wd, exp_w[63:32], exp_w[31:0]);
        end
      end
    end
  end

  function automatic logic [31:0] exp_head();
    return (model_q.size() == 0) ? 32'h0 : {24'h0, model_q[0]};
  endfunction

  task automatic expect_write(input logic [7:0] code);
    wr_q.push_back({BASE + 32'(wr_idx) * 32'd4, 24'h0, code});
    wr_idx = (wr_idx + 1) % DEPTH;
  endtask

  task automatic push_key(input logic [7:0] code);
    key_code   = code;
    data_ready = 1'b1;
    if (model_q.size() < DEPTH) begin
      model_q.push_back(code);
      expect_write(code);
    end else begin
      exp_ovf = 1'b1;
    end
    @(posedge clk); #1;
    data_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pop_one();
    pop = 1'b1;
    @(posedge clk); #1;
    pop = 1'b0;
    if (model_q.size() > 0) void'(model_q.pop_front());
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_q.delete();
    wr_idx  = 0;
    exp_ovf = 1'b0;
  endtask

  task automatic check_writes_done(input string tag);
    tests++;
    if (wr_q.size() != 0) begin
      fails++;
      $display("FAIL %s_missing_writes: got %0d pending, required 0", tag, wr_q.size());
      wr_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if ({count, empty, full, overflow, mem_we} !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_flags: got cnt=%0d e=%b f=%b o=%b we=%b, required 0 1 0 0 0",
               count, empty, full, overflow, mem_we);
    end
    tests++;
    if ({rd_data, mem_addr, mem_wd} !== 96'h0) begin
      fails++;
      $display("FAIL reset_data: got rd=%h a=%h wd=%h, required 0", rd_data, mem_addr, mem_wd);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    push_key(8'h1C);
    push_key(8'h32);
    push_key(8'h21);
    tests++;
    if (count !== 5'd3) begin
      fails++; $display("FAIL basic_count: got %0d, required 3", count);
    end
    tests++;
    if (rd_data !== 32'h0000_001C) begin
      fails++; $display("FAIL basic_head: got %h, required 0000001c", rd_data);
    end
    for (int i = 0; i < 3; i++) begin
      pop_one();
      tests++;
      if (rd_data !== exp_head()) begin
        fails++; $display("FAIL basic_pop%0d: got %h, required %h", i, rd_data, exp_head());
      end
    end
    tests++;
    if (empty !== 1'b1) begin
      fails++; $display("FAIL basic_empty: got %b, required 1", empty);
    end
    check_writes_done("basic");
  endtask

  task automatic test_held_level();
    do_clear();
    key_code   = 8'h45;
    data_ready = 1'b1;
    model_q.push_back(8'h45);
    expect_write(8'h45);
    repeat (10) @(posedge clk);
    #1 data_ready = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (count !== 5'd1 || rd_data !== 32'h45) begin
      fails++; $display("FAIL held_push: got cnt=%0d rd=%h, required 1 00000045", count, rd_data);
    end
    check_writes_done("held");
  endtask

  task automatic test_overflow();
    do_clear();
    for (int i = 0; i < 17; i++) push_key(8'(8'h60 + i));
    tests++;
    if ({full, overflow, count} !== {1'b1, exp_ovf, 5'd16}) begin
      fails++;
      $display("FAIL ovf_state: got f=%b o=%b cnt=%0d, required 1 %b 16", full, overflow, count, exp_ovf);
    end
    tests++;
    if (rd_data !== 32'h60) begin
      fails++; $display("FAIL ovf_head: got %h, required 00000060", rd_data);
    end
    check_writes_done("ovf");
    pop_one();
    tests++;
    if (overflow !== 1'b1 || count !== 5'd15) begin
      fails++; $display("FAIL ovf_sticky: got o=%b cnt=%0d, required 1 15", overflow, count);
    end
    do_clear();
    tests++;
    if ({overflow, empty, count} !== {1'b0, 1'b1, 5'd0}) begin
      fails++; $display("FAIL ovf_clear: got o=%b e=%b cnt=%0d, required 0 1 0", overflow, empty, count);
    end
  endtask

  task automatic test_full_push_pop();
    do_clear();
    for (int i = 0; i < 16; i++) push_key(8'(8'h80 + i));
    key_code   = 8'h77;
    data_ready = 1'b1;
    pop        = 1'b1;
    void'(model_q.pop_front());
    model_q.push_back(8'h77);
    expect_write(8'h77);
    @(posedge clk); #1;
    data_ready = 1'b0;
    pop        = 1'b0;
    @(posedge clk); #1;
    tests++;
    if ({count, overflow, full} !== {5'd16, 1'b0, 1'b1}) begin
      fails++; $display("FAIL fpp_state: got cnt=%0d o=%b f=%b, required 16 0 1", count, overflow, full);
    end
    check_writes_done("fpp");
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (rd_data !== exp_head()) begin
        fails++; $display("FAIL fpp_drain%0d: got %h, required %h", i, rd_data, exp_head());
      end
      pop_one();
    end
    tests++;
    if (empty !== 1'b1 || rd_data !== 32'h0) begin
      fails++; $display("FAIL fpp_empty: got e=%b rd=%h, required 1 0", empty, rd_data);
    end
  endtask

  task automatic test_empty_push_pop();
    do_clear();
    key_code   = 8'h5A;
    data_ready = 1'b1;
    pop        = 1'b1;
    model_q.push_back(8'h5A);
    expect_write(8'h5A);
    @(posedge clk); #1;
    data_ready = 1'b0;
    pop        = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (count !== 5'd1 || rd_data !== 32'h5A) begin
      fails++; $display("FAIL epp_push: got cnt=%0d rd=%h, required 1 0000005a", count, rd_data);
    end
    check_writes_done("epp");
    do_clear();
    tests++;
    if ({count, overflow, rd_data} !== {5'd0, 1'b0, 32'h0}) begin
      fails++; $display("FAIL epp_clear: got cnt=%0d o=%b rd=%h, required 0 0 0", count, overflow, rd_data);
    end
  endtask

  task automatic test_reset_mid();
    do_clear();
    for (int i = 0; i < 5; i++) push_key(8'(8'h10 + i));
    tests++;
    if (count !== 5'd5) begin
      fails++; $display("FAIL rmid_fill: got %0d, required 5", count);
    end
    #2;
    rst_n      = 1'b0;
    data_ready = 1'b1;
    key_code   = 8'h99;
    #1;
    tests++;
    if ({count, empty, full, mem_we, rd_data, mem_addr, mem_wd} !== {5'd0, 1'b1, 1'b0, 1'b0, 96'h0}) begin
      fails++;
      $display("FAIL rmid_async: got cnt=%0d e=%b f=%b we=%b rd=%h a=%h wd=%h, required 0 1 0 0 0 0 0",
               count, empty, full, mem_we, rd_data, mem_addr, mem_wd);
    end
    model_q.delete();
    wr_idx  = 0;
    exp_ovf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (count !== 5'd0) begin
      fails++; $display("FAIL rmid_held_at_release: got cnt=%0d, required 0", count);
    end
    data_ready = 1'b0;
    @(posedge clk); #1;
    data_ready = 1'b1;
    model_q.push_back(8'h99);
    expect_write(8'h99);
    @(posedge clk); #1;
    data_ready = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (count !== 5'd1 || rd_data !== 32'h99) begin
      fails++; $display("FAIL rmid_repush: got cnt=%0d rd=%h, required 1 00000099", count, rd_data);
    end
    check_writes_done("rmid");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_held_level();
    test_overflow();
    test_full_push_pop();
    test_empty_push_pop();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
